// File: rtl/pito_irq_ctrl.sv
// rtl/pito_irq_ctrl.sv - per-hart machine interrupt controller for the barrel core
// Event bus layout: {hart_id[HART_CNT_WIDTH:0], data(mcause)[31:0], valid}.
module pito_irq_ctrl #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_HARTS-1:0]              sw_irq_set_i,
  input  logic [NUM_HARTS-1:0]              timer_irq_i,
  input  logic [NUM_HARTS-1:0]              ext_irq_i,
  input  logic [NUM_HARTS-1:0]              mvu_irq_i,
  input  logic [NUM_HARTS*32-1:0]           mie_i,
  input  logic [NUM_HARTS-1:0]              mstatus_mie_i,
  input  logic [NUM_HARTS-1:0]              mret_i,
  output logic [HART_CNT_WIDTH+33:0]        irq_evt_o,
  input  logic                              irq_ready_i,
  output logic [NUM_HARTS*32-1:0]           mip_o
);

  localparam logic [31:0] MCAUSE_SW  = 32'h8000_0003;
  localparam logic [31:0] MCAUSE_TMR = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_MVU = 32'h8000_0010;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                    state_q, state_d;
  logic [NUM_HARTS-1:0]      msip_q, mtip_q, meip_q, mvip_q, in_service_q;
  logic [HART_CNT_WIDTH-1:0] rr_ptr_q;
  logic [HART_CNT_WIDTH:0]   evt_hart_q;
  logic [31:0]               evt_cause_q;
  logic                      evt_valid_q;

  logic [NUM_HARTS-1:0]      elig;
  logic [31:0]               hart_cause [NUM_HARTS];
  logic                      found;
  logic [HART_CNT_WIDTH-1:0] sel_hart;
  logic [31:0]               sel_cause;
  logic                      accept;
  logic [HART_CNT_WIDTH-1:0] acc_hart;
  logic [NUM_HARTS-1:0]      acc_mask, clr_sw, clr_mvu;
  logic                      unused_mie;

  assign unused_mie = ^mie_i;

  always_comb begin
    elig = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      logic pe, ps, pt, pv;
      pe = meip_q[h] & mie_i[32*h+11];
      ps = msip_q[h] & mie_i[32*h+3];
      pt = mtip_q[h] & mie_i[32*h+7];
      pv = mvip_q[h] & mie_i[32*h+16];
      elig[h] = mstatus_mie_i[h] & ~in_service_q[h] & (pe | ps | pt | pv);
      if (pe)      hart_cause[h] = MCAUSE_EXT;
      else if (ps) hart_cause[h] = MCAUSE_SW;
      else if (pt) hart_cause[h] = MCAUSE_TMR;
      else         hart_cause[h] = MCAUSE_MVU;
    end
  end

  // Round-robin search starts just after the last accepted hart.
  always_comb begin
    int idx;
    found     = 1'b0;
    sel_hart  = '0;
    sel_cause = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_HARTS;
      if (!found && elig[idx]) begin
        found     = 1'b1;
        sel_hart  = idx[HART_CNT_WIDTH-1:0];
        sel_cause = hart_cause[idx];
      end
    end
  end

  assign accept   = (state_q == OFFER) && irq_ready_i;
  assign acc_hart = evt_hart_q[HART_CNT_WIDTH-1:0];
  assign acc_mask = {{(NUM_HARTS-1){1'b0}}, accept} << acc_hart;
  assign clr_sw   = acc_mask & {NUM_HARTS{evt_cause_q == MCAUSE_SW}};
  assign clr_mvu  = acc_mask & {NUM_HARTS{evt_cause_q == MCAUSE_MVU}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = OFFER;
      OFFER:   if (irq_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Set pulses are OR'ed in after the accept-clear so a coincident set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q       <= '0;
      mtip_q       <= '0;
      meip_q       <= '0;
      mvip_q       <= '0;
      in_service_q <= '0;
      rr_ptr_q     <= HART_CNT_WIDTH'(NUM_HARTS-1);
    end else begin
      mtip_q       <= timer_irq_i;
      meip_q       <= ext_irq_i;
      msip_q       <= (msip_q & ~clr_sw) | sw_irq_set_i;
      mvip_q       <= (mvip_q & ~clr_mvu) | mvu_irq_i;
      in_service_q <= (in_service_q & ~mret_i) | acc_mask;
      if (accept) rr_ptr_q <= acc_hart;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_hart_q  <= '0;
      evt_cause_q <= '0;
    end else if (state_q == IDLE) begin
      evt_valid_q <= found;
      evt_hart_q  <= found ? {1'b0, sel_hart} : '0;
      evt_cause_q <= found ? sel_cause : '0;
    end else if (irq_ready_i) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign irq_evt_o = {evt_hart_q, evt_cause_q, evt_valid_q};

  always_comb begin
    mip_o = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mip_o[32*h+3]  = msip_q[h];
      mip_o[32*h+7]  = mtip_q[h];
      mip_o[32*h+11] = meip_q[h];
      mip_o[32*h+16] = mvip_q[h];
    end
  end

endmodule

// File: tb/tb_pito_irq_ctrl.sv
// tb/tb_pito_irq_ctrl.sv - scoreboard bench for pito_irq_ctrl
module tb_pito_irq_ctrl;
  localparam int N  = 8;
  localparam int HW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    sw_irq_set_i, timer_irq_i, ext_irq_i, mvu_irq_i;
  logic [N*32-1:0] mie_i;
  logic [N-1:0]    mstatus_mie_i, mret_i;
  logic [HW+33:0]  irq_evt_o;
  logic            irq_ready_i;
  logic [N*32-1:0] mip_o;

  always #5 clk = ~clk;

  pito_irq_ctrl #(.NUM_HARTS(N), .HART_CNT_WIDTH(HW)) dut (
    .clk(clk), .rst(rst), .sw_irq_set_i(sw_irq_set_i), .timer_irq_i(timer_irq_i),
    .ext_irq_i(ext_irq_i), .mvu_irq_i(mvu_irq_i), .mie_i(mie_i),
    .mstatus_mie_i(mstatus_mie_i), .mret_i(mret_i), .irq_evt_o(irq_evt_o),
    .irq_ready_i(irq_ready_i), .mip_o(mip_o)
  );

  logic          ev_valid;
  logic [31:0]   ev_data;
  logic [HW:0]   ev_hart;
  assign ev_valid = irq_evt_o[0];
  assign ev_data  = irq_evt_o[32:1];
  assign ev_hart  = irq_evt_o[HW+33:33];

  typedef struct {logic [HW:0] hart; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ev_valid && irq_ready_i) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got hart %0d data %h expected none", ev_hart, ev_data);
      end else begin
        e = exp_q.pop_front();
        check("evt_hart", 64'(ev_hart), 64'(e.hart));
        check("evt_data", 64'(ev_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int h, input logic [31:0] d);
    exp_t e;
    e.hart = (HW+1)'(h);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  function automatic logic [31:0] mip(input int h);
    return mip_o[32*h +: 32];
  endfunction

  task automatic set_mie(input int h, input logic [31:0] v);
    mie_i[32*h +: 32] = v;
  endtask

  task automatic do_reset();
    sw_irq_set_i = '0; timer_irq_i = '0; ext_irq_i = '0; mvu_irq_i = '0;
    mie_i = '0; mstatus_mie_i = '0; mret_i = '0; irq_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // single event, hold, accept, re-trigger after mret
    do_reset();
    check("rst_valid", 64'(ev_valid), 64'd0);
    check("rst_mip", 64'(mip_o == '0), 64'd1);
    set_mie(0, 32'h800); mstatus_mie_i[0] = 1'b1; ext_irq_i[0] = 1'b1;
    tick();
    check("t1_mip", 64'(mip(0)), 64'h800);
    check("t1_no_valid_yet", 64'(ev_valid), 64'd0);
    tick();
    check("t1_valid", 64'(ev_valid), 64'd1);
    check("t1_hart", 64'(ev_hart), 64'd0);
    check("t1_data", 64'(ev_data), 64'h8000000B);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_hold_valid", 64'(ev_valid), 64'd1);
      check("t1_hold_data", 64'(ev_data), 64'h8000000B);
    end
    push(0, 32'h8000000B);
    irq_ready_i = 1'b1;
    tick();
    check("t1_valid_drop", 64'(ev_valid), 64'd0);
    repeat (4) tick();
    check("t1_no_reoffer", 64'(ev_valid), 64'd0);
    push(0, 32'h8000000B);
    mret_i[0] = 1'b1;
    tick();
    mret_i[0] = 1'b0;
    drain("t1_retrigger");

    // cause priority and sticky clear
    do_reset();
    set_mie(2, 32'h10888); mstatus_mie_i[2] = 1'b1;
    sw_irq_set_i[2] = 1'b1; mvu_irq_i[2] = 1'b1;
    tick();
    sw_irq_set_i = '0; mvu_irq_i = '0;
    check("t2_mip_set", 64'(mip(2)), 64'h10008);
    tick();
    check("t2_valid", 64'(ev_valid), 64'd1);
    push(2, 32'h80000003);
    push(2, 32'h80000010);
    irq_ready_i = 1'b1;
    tick();
    check("t2_msip_clr", 64'(mip(2)), 64'h10000);
    mret_i[2] = 1'b1;
    tick();
    mret_i[2] = 1'b0;
    drain("t2_second");
    check("t2_mvip_clr", 64'(mip(2)), 64'h0);

    // round-robin order across two rounds
    do_reset();
    for (int h = 1; h < 8; h += 3) begin
      if (h == 7) break;
    end
    set_mie(1, 32'h800); set_mie(4, 32'h800); set_mie(6, 32'h800);
    mstatus_mie_i = 8'b0101_0010; ext_irq_i = 8'b0101_0010;
    irq_ready_i = 1'b1;
    push(1, 32'h8000000B); push(4, 32'h8000000B); push(6, 32'h8000000B);
    drain("t3_round1");
    push(1, 32'h8000000B); push(4, 32'h8000000B); push(6, 32'h8000000B);
    mret_i = 8'b0101_0010;
    tick();
    mret_i = '0;
    drain("t3_round2");

    // masking by mie and mstatus.mie
    do_reset();
    set_mie(5, 32'h888); mstatus_mie_i[5] = 1'b1; irq_ready_i = 1'b1;
    mvu_irq_i[5] = 1'b1;
    tick();
    mvu_irq_i = '0;
    check("t4_mip", 64'(mip(5)), 64'h10000);
    repeat (3) tick();
    check("t4_masked", 64'(ev_valid), 64'd0);
    push(5, 32'h80000010);
    set_mie(5, 32'h10888);
    tick();
    check("t4_unmask_lat", 64'(ev_valid), 64'd1);
    drain("t4_unmask");
    do_reset();
    set_mie(5, 32'h10000); irq_ready_i = 1'b1;
    mvu_irq_i[5] = 1'b1;
    tick();
    mvu_irq_i = '0;
    repeat (3) tick();
    check("t4_gmask", 64'(ev_valid), 64'd0);
    push(5, 32'h80000010);
    mstatus_mie_i[5] = 1'b1;
    tick();
    check("t4_gunmask_lat", 64'(ev_valid), 64'd1);
    drain("t4_gunmask");

    // set pulse colliding with accept-clear
    do_reset();
    set_mie(3, 32'h8); mstatus_mie_i[3] = 1'b1;
    sw_irq_set_i[3] = 1'b1;
    tick();
    sw_irq_set_i = '0;
    push(3, 32'h80000003);
    tick();
    check("t5_valid", 64'(ev_valid), 64'd1);
    irq_ready_i = 1'b1; sw_irq_set_i[3] = 1'b1;
    tick();
    irq_ready_i = 1'b0; sw_irq_set_i = '0;
    check("t5_msip_kept", 64'(mip(3)), 64'h8);
    check("t5_valid_drop", 64'(ev_valid), 64'd0);
    push(3, 32'h80000003);
    irq_ready_i = 1'b1; mret_i[3] = 1'b1;
    tick();
    mret_i = '0;
    drain("t5_second");

    // reset while an event is in OFFER
    do_reset();
    set_mie(0, 32'h800); set_mie(2, 32'h800);
    mstatus_mie_i = 8'b0000_0101; ext_irq_i = 8'b0000_0101;
    tick();
    tick();
    push(0, 32'h8000000B);
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0;
    tick();
    check("t6_offer_h2", 64'(ev_hart), 64'd2);
    check("t6_offer_valid", 64'(ev_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", 64'(ev_valid), 64'd0);
    check("t6_rst_mip", 64'(mip_o == '0), 64'd1);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    push(0, 32'h8000000B); push(2, 32'h8000000B);
    tick();
    check("t6_post_e1", 64'(ev_valid), 64'd0);
    tick();
    check("t6_post_valid", 64'(ev_valid), 64'd1);
    check("t6_post_prio", 64'(ev_hart), 64'd0);
    irq_ready_i = 1'b1;
    drain("t6_post");

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pito_irq_ctrl.md
Name: pito_irq_ctrl

Overview:
- Per-hart machine interrupt controller for the 8-hart barrel core.
- Collects software, timer, external and MVU-completion interrupt sources per hart and maintains each hart's MIP image.
- Masks pending interrupts with the core's per-hart MIE/MSTATUS.MIE and emits one irq_evt_t at a time to the core's trap unit over a valid/ready handshake.
- Arbitrates round-robin across harts; a hart is blocked from further events until it signals MRET.

Parameters:
NUM_HARTS, 8, number of harts served
HART_CNT_WIDTH, $clog2(NUM_HARTS), hart index width; the hart_id field in the event is HART_CNT_WIDTH+1 bits

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
sw_irq_set_i  in  NUM_HARTS  one-cycle pulse per hart; sets sticky MSIP
timer_irq_i  in  NUM_HARTS  level per hart; drives MTIP
ext_irq_i  in  NUM_HARTS  level per hart; drives MEIP
mvu_irq_i  in  NUM_HARTS  one-cycle pulse per hart from MVU done; sets sticky MVIP
mie_i  in  NUM_HARTS*32  per-hart MIE CSR, hart h at bits [32h+31:32h]
mstatus_mie_i  in  NUM_HARTS  per-hart MSTATUS.MIE global enable
mret_i  in  NUM_HARTS  one-cycle pulse; hart has executed MRET
irq_evt_o  out  irq_evt_t  {hart_id, data = mcause, valid}
irq_ready_i  in  1  trap unit accepts irq_evt_o this cycle
mip_o  out  NUM_HARTS*32  per-hart MIP for CSR_MIP reads, same packing as mie_i

Behaviour:
- Reset values: all pending bits 0, in_service 0, state IDLE, irq_evt_o = 0 (valid 0), mip_o = 0, rr_ptr = NUM_HARTS-1 so hart 0 has first priority.
- MIP image per hart is registered. Only bits 3 (MSIP), 7 (MTIP), 11 (MEIP) and 16 (MVIP) can be set; all other bits read 0.
- MTIP and MEIP are the registered copies of timer_irq_i and ext_irq_i. They are not cleared by the controller.
- MSIP and MVIP are sticky. They are set by a pulse and cleared only when an event of that cause is accepted.
- If a set pulse and an accept-clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- A hart is eligible when all of the following hold: mstatus_mie_i[h]=1, in_service[h]=0, and (mip[h] & mie[h]) != 0.
- Cause priority within a hart: MEIP > MSIP > MTIP > MVIP.
- mcause values: 0x8000000B, 0x80000003, 0x80000007, 0x80000010 respectively.
- FSM has two states.
  - IDLE: search harts starting at rr_ptr+1 modulo NUM_HARTS and take the first eligible one. Register hart_id (upper bit 0), mcause and valid=1, then go to OFFER. If none is eligible, stay in IDLE with valid=0.
  - OFFER: irq_evt_o is held stable, and valid stays 1, until irq_ready_i=1. The event is never retracted, even if the source deasserts or is masked meanwhile.
- On accept (OFFER with irq_ready_i=1): valid goes to 0 next cycle, in_service[h] is set, rr_ptr becomes h, the sticky bit for the cause is cleared if it is MSIP or MVIP, and the FSM returns to IDLE.
- Latency: a source asserted before clock edge E appears in mip_o after E. With the hart enabled and the FSM in IDLE, valid=1 follows after edge E+1. Minimum spacing between successive events is 2 cycles (one OFFER cycle, one IDLE cycle).
- mret_i[h] clears in_service[h] at the next edge. If mret_i[h] coincides with acceptance of an event for the same hart, the accept wins and in_service stays 1.
- A level source still pending after MRET re-triggers an event for that hart.
- Synchronous reset in any state returns everything to reset values at the next edge, including dropping a valid event in flight. Pending state is lost.
- mie_i and mstatus_mie_i are sampled only in IDLE and have no effect on an event already in OFFER.

Test Plan:
- Single event: reset; mie[0]=0x800, mstatus_mie[0]=1, ext_irq_i[0]=1 before edge 1 -> mip_o[11]=1 after edge 1; valid=1, hart_id=0, data=0x8000000B after edge 2. Hold ready=0 for 3 cycles -> event stable. Ready=1 -> valid=0 next cycle, no re-offer until mret_i[0].
- Priority and sticky clear: hart 2 with mie=0x10888, sw pulse and mvu pulse in the same cycle -> first event data=0x80000003 and mip bit 3 clears on accept. mret, then the second event has data=0x80000010.
- Round-robin: harts 1, 4 and 6 each hold ext_irq with ready tied 1 -> grants in order 1, 4, 6. MRET all three with sources held -> next grant order is again 1, 4, 6 with rr_ptr=6.
- Masking: mvu pulse on hart 5 with mie bit16=0 -> mip_o bit 16 set, no event. Set mie bit16 -> event 0x80000010 follows 1 cycle later. mstatus_mie=0 blocks events the same way.
- Set/clear collision: hart 3 MSIP event in OFFER; sw_irq_set_i[3] pulses in the same cycle as accept -> MSIP stays 1. After mret_i[3] a second 0x80000003 event is issued.
- Reset mid-operation: rst=1 for 1 cycle while in OFFER -> valid=0, mip_o=0 after the edge, hart 0 has priority again. Level sources still high -> new event issued 2 cycles after rst falls.
